// File: rtl/cgra_pe_pkg.sv
// rtl/cgra_pe_pkg.sv - context word layout, op codes and sequencer states for the CGRA PE
package cgra_pe_pkg;

  localparam int CTX_W        = 35;
  localparam int OP_LSB       = 0;
  localparam int OP_W         = 4;
  localparam int SRC_W        = 4;
  localparam int SRCA_LSB     = 4;
  localparam int SRCB_LSB     = 8;
  localparam int IMM_EN_BIT   = 12;
  localparam int IMM_LSB      = 13;
  localparam int IMM_W        = 8;
  localparam int DST_LSB      = 21;
  localparam int DST_W        = 3;
  localparam int WB_EN_BIT    = 24;
  localparam int MASK_LSB     = 25;
  localparam int MASK_W       = 8;
  localparam int PRED_EN_BIT  = 33;
  localparam int PRED_INV_BIT = 34;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_MUL   = 4'd8,
    OP_PASSA = 4'd9,
    OP_CMPLT = 4'd10,
    OP_CMPEQ = 4'd11,
    OP_HALT  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // NOP, HALT and the reserved codes 12-14 never touch registers or edges.
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd11);
  endfunction

endpackage

// File: rtl/cgra_pe_alu.sv
// rtl/cgra_pe_alu.sv - combinational functional unit of the CGRA PE
module cgra_pe_alu
  import cgra_pe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              pred_out,
  output logic              pred_we
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  always_comb begin
    result   = '0;
    pred_out = 1'b0;
    pred_we  = 1'b0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SHL:   result = a << b[SH_W-1:0];
      OP_SHR:   result = a >> b[SH_W-1:0];
      OP_MUL:   result = a * b;
      OP_PASSA: result = a;
      OP_CMPLT: begin
        pred_out = (a < b);
        pred_we  = 1'b1;
        result   = DATA_W'(pred_out);
      end
      OP_CMPEQ: begin
        pred_out = (a == b);
        pred_we  = 1'b1;
        result   = DATA_W'(pred_out);
      end
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cgra_pe_ctx.sv
// rtl/cgra_pe_ctx.sv - context-sequenced CGRA processing element with loop count and halt
module cgra_pe_ctx
  import cgra_pe_pkg::*;
#(
  parameter int NUM_EDGES = 4,
  parameter int DATA_W    = 32,
  parameter int CTX_DEPTH = 16,
  parameter int REG_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          start,
  input  logic [15:0]                   num_iter,
  input  logic [$clog2(CTX_DEPTH):0]    ctx_len,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(CTX_DEPTH)-1:0]  cfg_addr,
  input  logic [CTX_W-1:0]              cfg_data,
  input  logic [NUM_EDGES*DATA_W-1:0]   edge_in,
  output logic [NUM_EDGES*DATA_W-1:0]   edge_out,
  output logic [NUM_EDGES-1:0]          edge_out_vld,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(CTX_DEPTH)-1:0]  pc
);

  localparam int AW = $clog2(CTX_DEPTH);
  localparam int LW = AW + 1;

  state_e              state_q, state_d;
  logic [CTX_W-1:0]    ctx_mem [CTX_DEPTH];
  logic [DATA_W-1:0]   regs    [REG_DEPTH];
  logic                pred_q;
  logic [15:0]         iter_q, num_iter_q;
  logic [LW-1:0]       len_q, len_d;

  logic [CTX_W-1:0]    ctx_word;
  logic [OP_W-1:0]     op;
  logic [SRC_W-1:0]    src_a, src_b;
  logic [DST_W-1:0]    dst;
  logic [IMM_W-1:0]    imm;
  logic                imm_en, wb_en, pred_en, pred_inv;
  logic [DATA_W-1:0]   a_val, b_src, b_val, result;
  logic                pred_out, pred_we;
  logic                enabled, do_write, halt_now, last_ctx, last_iter, cfg_we;
  logic                unused_ctx_bits;

  assign ctx_word = ctx_mem[pc];
  assign op       = ctx_word[OP_LSB +: OP_W];
  assign src_a    = ctx_word[SRCA_LSB +: SRC_W];
  assign src_b    = ctx_word[SRCB_LSB +: SRC_W];
  assign imm_en   = ctx_word[IMM_EN_BIT];
  assign imm      = ctx_word[IMM_LSB +: IMM_W];
  assign dst      = ctx_word[DST_LSB +: DST_W];
  assign wb_en    = ctx_word[WB_EN_BIT];
  assign pred_en  = ctx_word[PRED_EN_BIT];
  assign pred_inv = ctx_word[PRED_INV_BIT];
  // out_mask bits beyond NUM_EDGES are intentionally ignored.
  assign unused_ctx_bits = ^ctx_word;

  // Source 0..7 is an edge channel, 8..15 a local register; absent ones read 0.
  always_comb begin
    a_val = '0;
    b_src = '0;
    for (int k = 0; k < NUM_EDGES; k++) begin
      if (src_a == {1'b0, 3'(k)}) a_val = edge_in[k*DATA_W +: DATA_W];
      if (src_b == {1'b0, 3'(k)}) b_src = edge_in[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < REG_DEPTH; k++) begin
      if (src_a == {1'b1, 3'(k)}) a_val = regs[k];
      if (src_b == {1'b1, 3'(k)}) b_src = regs[k];
    end
  end

  assign b_val = imm_en ? DATA_W'(imm) : b_src;

  cgra_pe_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op),
    .a        (a_val),
    .b        (b_val),
    .result   (result),
    .pred_out (pred_out),
    .pred_we  (pred_we)
  );

  assign enabled   = (state_q == ST_RUN) && (!pred_en || (pred_q ^ pred_inv));
  assign do_write  = enabled && op_writes(op);
  assign halt_now  = enabled && (op == OP_HALT);
  assign last_ctx  = ({1'b0, pc} == (len_q - LW'(1)));
  assign last_iter = ((iter_q + 16'd1) == num_iter_q);
  assign cfg_we    = cfg_valid && cfg_ready && !start;

  always_comb begin
    if ((ctx_len == '0) || (ctx_len > LW'(CTX_DEPTH))) len_d = LW'(CTX_DEPTH);
    else                                               len_d = ctx_len;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (num_iter == 16'd0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (halt_now || (last_ctx && last_iter)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    cfg_ready = (state_q != ST_RUN);
  end

  // Sequencer: pc, iteration count and the per-run latched bounds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc         <= '0;
      iter_q     <= '0;
      num_iter_q <= '0;
      len_q      <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state_d == ST_DONE) && ((state_q != ST_DONE) || start);
      if (state_q != ST_RUN) begin
        if (start) begin
          pc         <= '0;
          iter_q     <= '0;
          num_iter_q <= num_iter;
          len_q      <= len_d;
        end
      end else if (!halt_now) begin
        if (last_ctx) begin
          pc     <= '0;
          iter_q <= iter_q + 16'd1;
        end else begin
          pc <= pc + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CTX_DEPTH; i++) ctx_mem[i] <= '0;
    end else if (cfg_we) begin
      ctx_mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
      pred_q       <= 1'b0;
      edge_out     <= '0;
      edge_out_vld <= '0;
    end else begin
      edge_out_vld <= '0;
      if (do_write) begin
        for (int k = 0; k < REG_DEPTH; k++) begin
          if (wb_en && (dst == 3'(k))) regs[k] <= result;
        end
        for (int k = 0; k < NUM_EDGES; k++) begin
          if (ctx_word[MASK_LSB + k]) begin
            edge_out[k*DATA_W +: DATA_W] <= result;
            edge_out_vld[k]              <= 1'b1;
          end
        end
      end
      if (enabled && pred_we) pred_q <= pred_out;
    end
  end

endmodule

// File: tb/tb_cgra_pe_ctx.sv
// tb/tb_cgra_pe_ctx.sv - directed self-checking bench for cgra_pe_ctx
module tb_cgra_pe_ctx;

  localparam int NE = 4;
  localparam int DW = 32;
  localparam int CD = 16;
  localparam int RD = 4;

  logic            clk, rst_n, start, cfg_valid, cfg_ready, busy, done;
  logic [15:0]     num_iter;
  logic [4:0]      ctx_len;
  logic [3:0]      cfg_addr, pc;
  logic [34:0]     cfg_data;
  logic [DW-1:0]   e [NE];
  logic [NE*DW-1:0] edge_in, edge_out;
  logic [NE-1:0]   vld;

  assign edge_in = {e[3], e[2], e[1], e[0]};

  cgra_pe_ctx #(.NUM_EDGES(NE), .DATA_W(DW), .CTX_DEPTH(CD), .REG_DEPTH(RD)) dut (
    .CLK(clk), .RST_N(rst_n), .start(start), .num_iter(num_iter), .ctx_len(ctx_len),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .edge_in(edge_in), .edge_out(edge_out), .edge_out_vld(vld),
    .busy(busy), .done(done), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] mk(input logic [3:0] op, input logic [3:0] sa, input logic [3:0] sb,
                                     input logic ie, input logic [7:0] imm, input logic [2:0] dst,
                                     input logic wb, input logic [7:0] mask, input logic pe, input logic pi);
    return {pi, pe, mask, wb, dst, imm, ie, sb, sa, op};
  endfunction

  function automatic logic [DW-1:0] eo(input int k);
    return edge_out[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [34:0] word);
    cfg_addr  = addr;
    cfg_data  = word;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic go(input logic [15:0] ni, input logic [4:0] len);
    num_iter = ni;
    ctx_len  = len;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [3:0]  exp_vld;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL timeout: got 0x0, expected 0x1");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_exp, wraps, prev_pc;
    logic seen_done;

    vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'd1,      32'd0,        4'b0001};
    vecs[1]  = '{4'd2,  32'd5,        32'd7,      32'hFFFFFFFE, 4'b0001};
    vecs[2]  = '{4'd3,  32'hF0F0,     32'hFF00,   32'hF000,     4'b0001};
    vecs[3]  = '{4'd4,  32'hF0F0,     32'h0F0F,   32'hFFFF,     4'b0001};
    vecs[4]  = '{4'd5,  32'hFF,       32'h0F,     32'hF0,       4'b0001};
    vecs[5]  = '{4'd6,  32'd1,        32'd33,     32'd2,        4'b0001};
    vecs[6]  = '{4'd7,  32'h80000000, 32'd31,     32'd1,        4'b0001};
    vecs[7]  = '{4'd8,  32'h10000,    32'h10000,  32'd0,        4'b0001};
    vecs[8]  = '{4'd8,  32'd3,        32'd7,      32'd21,       4'b0001};
    vecs[9]  = '{4'd9,  32'h1234,     32'h5678,   32'h1234,     4'b0001};
    vecs[10] = '{4'd0,  32'hAAAA,     32'hBBBB,   32'h1234,     4'b0000};
    vecs[11] = '{4'd13, 32'd1,        32'd1,      32'h1234,     4'b0000};
    vecs[12] = '{4'd10, 32'd3,        32'd9,      32'd1,        4'b0001};
    vecs[13] = '{4'd11, 32'd5,        32'd6,      32'd0,        4'b0001};
    vecs[14] = '{4'd10, 32'd9,        32'd3,      32'd0,        4'b0001};

    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_iter = '0; ctx_len = '0;
    for (int k = 0; k < NE; k++) e[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge_out", edge_out, 0);
    chk("rst_vld", vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single-op vectors: ctx0 = op edge0,edge1 -> out0, one pass of one context.
    for (int i = 0; i < 15; i++) begin
      load(4'd0, mk(vecs[i].op, 4'd0, 4'd1, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0));
      e[0] = vecs[i].a;
      e[1] = vecs[i].b;
      go(16'd1, 5'd1);
      tick();
      chk($sformatf("alu[%0d]_result", i), eo(0), vecs[i].exp);
      chk($sformatf("alu[%0d]_vld", i), vld, vecs[i].exp_vld);
      chk($sformatf("alu[%0d]_done", i), done, 1);
    end

    // ADD edge0 + imm 5 -> out1, three passes of a one-entry context.
    load(4'd0, mk(4'd1, 4'd0, 4'd0, 1'b1, 8'd5, 3'd0, 1'b0, 8'b0010, 1'b0, 1'b0));
    e[0] = 32'd10;
    go(16'd3, 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("add3[%0d]_out1", i), eo(1), 32'd15);
      chk($sformatf("add3[%0d]_vld", i), vld, 4'b0010);
      chk($sformatf("add3[%0d]_done", i), done, (i == 2));
      chk($sformatf("add3[%0d]_busy", i), busy, (i != 2));
    end
    tick();
    chk("add3_done_low", done, 0);
    chk("add3_vld_low", vld, 0);

    // Accumulator through reg0, observed on edge0 strobes.
    load(4'd0, mk(4'd1, 4'd8, 4'd0, 1'b1, 8'd1, 3'd0, 1'b1, 8'h00, 1'b0, 1'b0));
    load(4'd1, mk(4'd9, 4'd8, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0));
    go(16'd4, 5'd2);
    acc_exp = 1; wraps = 0; prev_pc = 0; seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      tick();
      if (vld[0]) begin
        chk($sformatf("acc_val[%0d]", acc_exp), eo(0), acc_exp);
        acc_exp++;
      end
      if (busy && prev_pc == 1 && pc == 0) wraps++;
      prev_pc = pc;
      if (done) seen_done = 1'b1;
    end
    chk("acc_strobes", acc_exp - 1, 4);
    chk("acc_wraps", wraps, 3);
    chk("acc_done_seen", seen_done, 1);

    // Predication: compare then two mutually exclusive predicated writes.
    e[1] = 32'h111;
    e[2] = 32'h222;
    load(4'd0, mk(4'd10, 4'd0, 4'd0, 1'b1, 8'd7, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    load(4'd1, mk(4'd9, 4'd1, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b0));
    load(4'd2, mk(4'd9, 4'd2, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b1, 1'b1));
    for (int p = 0; p < 2; p++) begin
      e[0] = (p == 0) ? 32'd3 : 32'd9;
      go(16'd1, 5'd3);
      tick();
      chk($sformatf("pred[%0d]_cmp_vld", p), vld, 4'b0000);
      tick();
      chk($sformatf("pred[%0d]_ctx1_vld", p), vld, (p == 0) ? 4'b0001 : 4'b0000);
      tick();
      chk($sformatf("pred[%0d]_ctx2_vld", p), vld, (p == 0) ? 4'b0000 : 4'b0001);
      chk($sformatf("pred[%0d]_out0", p), eo(0), (p == 0) ? 32'h111 : 32'h222);
      chk($sformatf("pred[%0d]_done", p), done, 1);
    end

    // HALT at ctx1 stops the run before ctx2/ctx3.
    e[3] = 32'h333;
    load(4'd0, mk(4'd9, 4'd0, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'b0010, 1'b0, 1'b0));
    load(4'd1, mk(4'd15, 4'd0, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0));
    load(4'd2, mk(4'd9, 4'd3, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'b0100, 1'b0, 1'b0));
    load(4'd3, mk(4'd9, 4'd3, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'b1000, 1'b0, 1'b0));
    go(16'd10, 5'd4);
    tick();
    chk("halt_c1_busy", busy, 1);
    chk("halt_c1_vld", vld, 4'b0010);
    tick();
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    chk("halt_vld", vld, 0);
    repeat (3) tick();
    chk("halt_out2", eo(2), 0);
    chk("halt_out3", eo(3), 0);

    // cfg_valid together with start: write dropped, original ctx0 runs.
    e[0] = 32'hAAAA;
    e[1] = 32'hBBBB;
    load(4'd0, mk(4'd9, 4'd0, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0));
    num_iter = 16'd1; ctx_len = 5'd1; start = 1'b1;
    cfg_valid = 1'b1; cfg_addr = 4'd0;
    cfg_data = mk(4'd9, 4'd1, 4'd0, 1'b0, 8'd0, 3'd0, 1'b0, 8'h01, 1'b0, 1'b0);
    tick();
    start = 1'b0; cfg_valid = 1'b0;
    chk("cfgstart_ready", cfg_ready, 0);
    tick();
    chk("cfgstart_out0", eo(0), 32'hAAAA);

    // cfg_valid during RUN is refused.
    go(16'd3, 5'd1);
    chk("cfgrun_ready", cfg_ready, 0);
    cfg_valid = 1'b1;
    repeat (3) tick();
    cfg_valid = 1'b0;
    chk("cfgrun_done", done, 1);
    e[0] = 32'hCCCC;
    go(16'd1, 5'd1);
    tick();
    chk("cfgrun_ctx_kept", eo(0), 32'hCCCC);

    // Asynchronous reset mid-run, then a run over cleared (NOP) contexts.
    go(16'd100, 5'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_edge_out", edge_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cfg_ready", cfg_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    go(16'd2, 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("nop[%0d]_vld", i), vld, 0);
      chk($sformatf("nop[%0d]_out0", i), eo(0), 0);
      chk($sformatf("nop[%0d]_done", i), done, (i == 1));
    end

    // num_iter = 0 goes straight to DONE.
    go(16'd0, 5'd1);
    chk("zero_iter_done", done, 1);
    chk("zero_iter_busy", busy, 0);
    tick();
    chk("zero_iter_done_low", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
